// File: rtl/stopwatch_control_if.sv
// Button inputs and counter/display control outputs of the stopwatch control stage.
// The master side drives the raw buttons; the slave side is the control FSM.
interface stopwatch_control_if;
    logic       Btn_StartStop;
    logic       Btn_LapReset;
    logic       Enable;
    logic       Cnt_Nreset;
    logic       Hold;
    logic [2:0] State;

    modport master (
        output Btn_StartStop,
        output Btn_LapReset,
        input  Enable,
        input  Cnt_Nreset,
        input  Hold,
        input  State
    );

    modport slave (
        input  Btn_StartStop,
        input  Btn_LapReset,
        output Enable,
        output Cnt_Nreset,
        output Hold,
        output State
    );
endinterface

// File: rtl/stopwatch_control.sv
// Debounces the Start/Stop and Lap/Reset buttons into one-shot press events and runs
// the stopwatch FSM that drives the counter's Enable/Cnt_Nreset and the display Hold.
module stopwatch_control #(
    parameter int DEBOUNCE   = 20,
    parameter int CLR_CYCLES = 2
) (
    input  logic                NEclk,
    input  logic                Reset,
    stopwatch_control_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        LAP   = 3'd2,
        PAUSE = 3'd3,
        CLEAR = 3'd4
    } state_t;

    localparam logic [7:0] DB_LAST  = 8'(DEBOUNCE - 1);
    localparam logic [3:0] CLR_LAST = 4'(CLR_CYCLES - 1);

    // Bit 0 is Start/Stop, bit 1 is Lap/Reset throughout the conditioning logic.
    logic [1:0] btn_raw;
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] stable;
    logic [1:0] press;
    logic [7:0] db_cnt [2];

    state_t     state;
    state_t     next_state;
    logic [3:0] clr_cnt;
    logic       enable_q;
    logic       hold_q;
    logic       nreset_q;
    logic       next_enable;
    logic       next_hold;
    logic       next_nreset;
    logic       ss_evt;
    logic       lr_evt;

    assign btn_raw = {bus.Btn_LapReset, bus.Btn_StartStop};
    assign ss_evt  = press[0];
    assign lr_evt  = press[1];

    // A level change is accepted only after s2 has differed from the stable level for
    // DEBOUNCE consecutive cycles; press pulses for one cycle on an accepted rise.
    always_ff @(negedge NEclk or posedge Reset) begin
        if (Reset) begin
            sync1     <= '0;
            sync2     <= '0;
            stable    <= '0;
            press     <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            press <= '0;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    press[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 8'd1;
                end
            end
        end
    end

    // Start/Stop is checked first in every state so it wins over a simultaneous Lap/Reset.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (ss_evt) next_state = RUN;   else if (lr_evt) next_state = CLEAR;
            RUN:     if (ss_evt) next_state = PAUSE; else if (lr_evt) next_state = LAP;
            LAP:     if (ss_evt) next_state = PAUSE; else if (lr_evt) next_state = RUN;
            PAUSE:   if (ss_evt) next_state = RUN;   else if (lr_evt) next_state = CLEAR;
            CLEAR:   if (clr_cnt == CLR_LAST) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from next_state so the registered outputs change with State.
    always_comb begin
        next_enable = 1'b0;
        next_hold   = 1'b0;
        next_nreset = 1'b1;
        case (next_state)
            RUN:     next_enable = 1'b1;
            LAP: begin
                next_enable = 1'b1;
                next_hold   = 1'b1;
            end
            CLEAR:   next_nreset = 1'b0;
            default: ;
        endcase
    end

    always_ff @(negedge NEclk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            clr_cnt  <= '0;
            enable_q <= 1'b0;
            hold_q   <= 1'b0;
            nreset_q <= 1'b0;
        end else begin
            state    <= next_state;
            clr_cnt  <= (state == CLEAR) ? clr_cnt + 4'd1 : 4'd0;
            enable_q <= next_enable;
            hold_q   <= next_hold;
            nreset_q <= next_nreset;
        end
    end

    assign bus.State      = state;
    assign bus.Enable     = enable_q;
    assign bus.Hold       = hold_q;
    assign bus.Cnt_Nreset = nreset_q;

endmodule
